icache_burst: RTL and testbench

Parametrised direct-mapped instruction cache between the MultiCycle CPU fetch stage and the instruction bus. It is the successor to the single-word ICache. It adds:
- configurable geometry (lines, words per line);
- tag/valid storage with multi-word line refill over the IBus;
- a flush input;
- optional hit/miss statistics.

---
 rtl/icache_pkg.sv | 47 ++++
 rtl/icache_data_ram.sv | 40 ++++
 rtl/icache_burst.sv | 213 +++++++++++++++++++++
 tb/tb_icache_burst.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared definitions for the burst-refill instruction cache:
//   - state_t: controller state encoding
//   - *_bits(): address field width helpers (byte offset, word select,
//     line index, tag)
//   - addr_field(): generic extraction of a bit field from a byte address
//   Optional feature macro used by the cache top level: ICACHE_STATS_EN.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL_REQ,
    ST_REFILL_WAIT,
    ST_RESPOND
  } state_t;

  // Address fields are extracted from a zero-extended copy of the address,
  // so any ADDR_W up to this width is supported.
  localparam int ADDR_MAX_W = 64;

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int wsel_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_w, input int data_w,
                                  input int lines, input int words_per_line);
    return addr_w - off_bits(data_w) - wsel_bits(words_per_line) - idx_bits(lines);
  endfunction

  function automatic logic [ADDR_MAX_W-1:0] addr_field(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int lsb, input int width);
    logic [ADDR_MAX_W-1:0] mask;
    mask = (width >= ADDR_MAX_W) ? '1 :
           ((ADDR_MAX_W'(1) << width) - ADDR_MAX_W'(1));
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram
//   Synchronous single-port data store of LINES x WORDS_PER_LINE words.
//   A write and a read may not target different words in the same cycle;
//   the cache never reads while refilling.
// Ports:
//   i_Clk     clock
//   i_We      write enable (write i_WrData at i_Addr)
//   i_Re      read enable (o_RdData updated at the next edge)
//   i_Addr    word address {line index, word select}
//   i_WrData  write data
//   o_RdData  registered read data, holds between reads
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                                        i_Clk,
  input  logic                                                        i_We,
  input  logic                                                        i_Re,
  input  logic [idx_bits(LINES)+wsel_bits(WORDS_PER_LINE)-1:0]        i_Addr,
  input  logic [DATA_W-1:0]                                           i_WrData,
  output logic [DATA_W-1:0]                                           o_RdData
);

  localparam int DEPTH = LINES * WORDS_PER_LINE;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_Clk) begin
    if (i_We) begin
      mem[i_Addr] <= i_WrData;
    end
    if (i_Re) begin
      o_RdData <= mem[i_Addr];
    end
  end

endmodule

// File: rtl/icache_burst.sv
// icache_burst
//   Direct-mapped instruction cache with multi-word line refill over the
//   instruction bus (one outstanding read, fixed read latency of one cycle).
//   Optional feature: define ICACHE_STATS_EN to build saturating hit/miss
//   counters; otherwise o_HitCount/o_MissCount are tied to zero.
// Ports:
//   i_Clk, i_Rst        clock, asynchronous active-high reset
//   i_RdEn, i_Addr      fetch request (sampled while o_Stall=0)
//   i_Flush             invalidate every line
//   o_Stall, o_RdData   CPU hold and returned instruction
//   o_IBus_Address, o_IBus_Read, i_IBus_ReadData, i_IBus_WaitReq  refill bus
//   o_HitCount, o_MissCount  statistics
module icache_burst
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_RdEn,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic              i_Flush,
  output logic              o_Stall,
  output logic [DATA_W-1:0] o_RdData,
  output logic [ADDR_W-1:0] o_IBus_Address,
  output logic              o_IBus_Read,
  input  logic [DATA_W-1:0] i_IBus_ReadData,
  input  logic              i_IBus_WaitReq,
  output logic [31:0]       o_HitCount,
  output logic [31:0]       o_MissCount
);

  localparam int OFF_W  = off_bits(DATA_W);
  localparam int WSEL_W = wsel_bits(WORDS_PER_LINE);
  localparam int IDX_W  = idx_bits(LINES);
  localparam int TAG_W  = tag_bits(ADDR_W, DATA_W, LINES, WORDS_PER_LINE);
  localparam int LINE_LSB = OFF_W + WSEL_W;
  localparam int TAG_LSB  = OFF_W + WSEL_W + IDX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_LSB) - ADDR_W'(1));

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [WSEL_W-1:0] cnt;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic              flush_pend;
  logic [DATA_W-1:0] miss_word;
  logic [DATA_W-1:0] rd_hold;
  logic [DATA_W-1:0] ram_rdata;

  logic [IDX_W-1:0]  cur_idx, req_idx;
  logic [WSEL_W-1:0] cur_wsel, req_wsel;
  logic [TAG_W-1:0]  cur_tag;
  logic              lookup_hit, lookup_miss, accept, last_word, refill_done;
  logic              ram_we;
  logic [IDX_W+WSEL_W-1:0] ram_addr;

  // Field split of the latched request and of the incoming request
  assign cur_idx  = IDX_W'(addr_field(ADDR_MAX_W'(addr_q), LINE_LSB, IDX_W));
  assign cur_wsel = WSEL_W'(addr_field(ADDR_MAX_W'(addr_q), OFF_W, WSEL_W));
  assign cur_tag  = TAG_W'(addr_field(ADDR_MAX_W'(addr_q), TAG_LSB, TAG_W));
  assign req_idx  = IDX_W'(addr_field(ADDR_MAX_W'(i_Addr), LINE_LSB, IDX_W));
  assign req_wsel = WSEL_W'(addr_field(ADDR_MAX_W'(i_Addr), OFF_W, WSEL_W));

  // A flush in the lookup cycle forces a miss so the stale line is never used
  assign lookup_hit  = (state == ST_LOOKUP) && valid[cur_idx] &&
                       (tags[cur_idx] == cur_tag) && !i_Flush;
  assign lookup_miss = (state == ST_LOOKUP) && !lookup_hit;
  assign accept      = i_RdEn && ((state == ST_IDLE) || (state == ST_RESPOND) || lookup_hit);
  assign last_word   = (cnt == WSEL_W'(WORDS_PER_LINE - 1));
  assign refill_done = (state == ST_REFILL_WAIT) && last_word;

  // Bus address keeps the line of the missed request and walks the word counter
  assign o_IBus_Address = (addr_q & LINE_MASK) | (ADDR_W'(cnt) << OFF_W);

  // Single RAM port: refill writes, otherwise the incoming request is read
  assign ram_we   = (state == ST_REFILL_WAIT);
  assign ram_addr = ram_we ? {cur_idx, cnt} : {req_idx, req_wsel};

  icache_data_ram #(
    .DATA_W         (DATA_W),
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data_ram (
    .i_Clk    (i_Clk),
    .i_We     (ram_we),
    .i_Re     (accept),
    .i_Addr   (ram_addr),
    .i_WrData (i_IBus_ReadData),
    .o_RdData (ram_rdata)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:        if (i_RdEn) next_state = ST_LOOKUP;
      ST_LOOKUP:      if (lookup_hit) next_state = i_RdEn ? ST_LOOKUP : ST_IDLE;
                      else next_state = ST_REFILL_REQ;
      ST_REFILL_REQ:  if (!i_IBus_WaitReq) next_state = ST_REFILL_WAIT;
      ST_REFILL_WAIT: next_state = last_word ? ST_RESPOND : ST_REFILL_REQ;
      ST_RESPOND:     next_state = i_RdEn ? ST_LOOKUP : ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase
  end

  // Returned data is live during a hit/respond cycle and held otherwise
  always_comb begin
    o_Stall     = lookup_miss || (state == ST_REFILL_REQ) || (state == ST_REFILL_WAIT);
    o_IBus_Read = (state == ST_REFILL_REQ);
    o_RdData    = rd_hold;
    if (lookup_hit) begin
      o_RdData = ram_rdata;
    end else if (state == ST_RESPOND) begin
      o_RdData = miss_word;
    end
  end

  // Request latch, refill counter, valid bits and the deferred flush.
  // A flush seen during a refill leaves every line, including the one being
  // filled, invalid once the refill completes.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      addr_q     <= '0;
      cnt        <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
      miss_word  <= '0;
      rd_hold    <= '0;
    end else begin
      if (accept) begin
        addr_q <= i_Addr;
      end
      if (lookup_miss) begin
        cnt <= '0;
      end
      if (lookup_hit) begin
        rd_hold <= ram_rdata;
      end
      if (state == ST_RESPOND) begin
        rd_hold <= miss_word;
      end
      if (state == ST_REFILL_WAIT) begin
        cnt <= cnt + WSEL_W'(1);
        if (cnt == cur_wsel) begin
          miss_word <= i_IBus_ReadData;
        end
      end
      if ((state == ST_REFILL_REQ) || (state == ST_REFILL_WAIT)) begin
        if (i_Flush) begin
          flush_pend <= 1'b1;
        end
      end else if (i_Flush) begin
        valid <= '0;
      end
      if (refill_done) begin
        flush_pend <= 1'b0;
        if (flush_pend || i_Flush) begin
          valid <= '0;
        end else begin
          valid[cur_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (refill_done) begin
      tags[cur_idx] <= cur_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;

  // Saturating statistics; a flush clears them
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (i_Flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit && (hit_cnt != 32'hFFFF_FFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (lookup_miss && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign o_HitCount  = hit_cnt;
  assign o_MissCount = miss_cnt;
`else
  assign o_HitCount  = 32'd0;
  assign o_MissCount = 32'd0;
`endif

endmodule

// File: tb/tb_icache_burst.sv
// tb_icache_burst
//   Directed bench for icache_burst with default geometry. The bus model
//   answers every read with its own address. Fetch expectations go into a
//   queue and a monitor compares them whenever the cache returns data.
module tb_icache_burst;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_RdEn;
  logic [31:0] i_Addr;
  logic        i_Flush;
  logic        o_Stall;
  logic [31:0] o_RdData;
  logic [31:0] o_IBus_Address;
  logic        o_IBus_Read;
  logic [31:0] i_IBus_ReadData;
  logic        i_IBus_WaitReq;
  logic [31:0] o_HitCount;
  logic [31:0] o_MissCount;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] bus_log[$];
  logic [31:0] wait_log[$];
  int          wait_left;
  int          stall_total;
  bit          outstanding;

  icache_burst dut (
    .i_Clk           (i_Clk),
    .i_Rst           (i_Rst),
    .i_RdEn          (i_RdEn),
    .i_Addr          (i_Addr),
    .i_Flush         (i_Flush),
    .o_Stall         (o_Stall),
    .o_RdData        (o_RdData),
    .o_IBus_Address  (o_IBus_Address),
    .o_IBus_Read     (o_IBus_Read),
    .i_IBus_ReadData (i_IBus_ReadData),
    .i_IBus_WaitReq  (i_IBus_WaitReq),
    .o_HitCount      (o_HitCount),
    .o_MissCount     (o_MissCount)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one fetch and return once the cache has accepted it
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp);
    int g;
    exp_q.push_back(exp);
    i_RdEn = 1'b1;
    i_Addr = addr;
    g = 0;
    @(negedge i_Clk);
    while (o_Stall && g < 100) begin
      @(negedge i_Clk);
      g++;
    end
    checkOutput("accept_stall", {31'd0, o_Stall}, 32'd0);
    @(posedge i_Clk);
    #1;
    i_RdEn = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge i_Clk);
      g++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic checkBusLog(input string name, input int start, input logic [31:0] base);
    checkOutput({name, "_nreads"}, 32'(bus_log.size() - start), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (start + i < bus_log.size()) begin
        checkOutput(name, bus_log[start+i], base + 32'(4 * i));
      end
    end
  endtask

  // Bus model: returns the address as data, optionally stalls a read
  initial begin
    i_IBus_WaitReq  = 1'b0;
    i_IBus_ReadData = '0;
    wait_left       = 0;
    forever begin
      @(negedge i_Clk);
      if (o_IBus_Read && !i_Rst) begin
        i_IBus_ReadData = o_IBus_Address;
        if (wait_left > 0) begin
          i_IBus_WaitReq = 1'b1;
          wait_left--;
          wait_log.push_back(o_IBus_Address);
        end else begin
          i_IBus_WaitReq = 1'b0;
          bus_log.push_back(o_IBus_Address);
        end
      end else begin
        i_IBus_WaitReq = 1'b0;
      end
    end
  end

  // Monitor: a request accepted at an edge is answered in the first later
  // cycle with o_Stall low
  initial begin
    logic [31:0] exp;
    outstanding = 1'b0;
    stall_total = 0;
    forever begin
      @(negedge i_Clk);
      if (i_Rst) begin
        outstanding = 1'b0;
      end else begin
        if (o_Stall) stall_total++;
        if (outstanding && !o_Stall) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL rd_data: got 0x%08h with no response expected", o_RdData);
          end else begin
            exp = exp_q.pop_front();
            checkOutput("rd_data", o_RdData, exp);
          end
          outstanding = 1'b0;
        end
        if (!o_Stall && i_RdEn) outstanding = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start, s0, g;
    logic [31:0] exp_hit, exp_miss;
    i_Rst   = 1'b1;
    i_RdEn  = 1'b0;
    i_Addr  = '0;
    i_Flush = 1'b0;
    repeat (2) @(negedge i_Clk);
    checkOutput("rst_stall", {31'd0, o_Stall}, 32'd0);
    checkOutput("rst_busread", {31'd0, o_IBus_Read}, 32'd0);
    checkOutput("rst_busaddr", o_IBus_Address, 32'd0);
    checkOutput("rst_rddata", o_RdData, 32'd0);
    checkOutput("rst_hits", o_HitCount, 32'd0);
    checkOutput("rst_misses", o_MissCount, 32'd0);
    i_Rst = 1'b0;
    @(posedge i_Clk);
    #1;

    $display("[TB] cold miss at 0x04");
    start = bus_log.size();
    s0 = stall_total;
    applyStimulus(32'h04, 32'h04);
    drain("t1_drain");
    checkBusLog("t1_bus", start, 32'h00);
    checkOutput("t1_stall_cycles", 32'(stall_total - s0), 32'd9);

    $display("[TB] back-to-back hits");
    start = bus_log.size();
    s0 = stall_total;
    applyStimulus(32'h00, 32'h00);
    applyStimulus(32'h08, 32'h08);
    applyStimulus(32'h0C, 32'h0C);
    drain("t2_drain");
    checkOutput("t2_bus_reads", 32'(bus_log.size() - start), 32'd0);
    checkOutput("t2_stall_cycles", 32'(stall_total - s0), 32'd0);
`ifdef ICACHE_STATS_EN
    exp_hit = 32'd3; exp_miss = 32'd1;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    checkOutput("t2_hits", o_HitCount, exp_hit);
    checkOutput("t2_misses", o_MissCount, exp_miss);

    $display("[TB] miss at 0x48 with bus wait");
    start = bus_log.size();
    s0 = stall_total;
    wait_left = 2;
    applyStimulus(32'h48, 32'h48);
    drain("t3_drain");
    checkBusLog("t3_bus", start, 32'h40);
    checkOutput("t3_stall_cycles", 32'(stall_total - s0), 32'd11);
    checkOutput("t3_wait_n", 32'(wait_log.size()), 32'd2);
    foreach (wait_log[i]) checkOutput("t3_wait_addr", wait_log[i], 32'h40);

    $display("[TB] conflict 0x100 vs 0x00");
    start = bus_log.size();
    applyStimulus(32'h100, 32'h100);
    drain("t4a_drain");
    checkBusLog("t4a_bus", start, 32'h100);
    start = bus_log.size();
    applyStimulus(32'h00, 32'h00);
    drain("t4b_drain");
    checkBusLog("t4b_bus", start, 32'h00);

    $display("[TB] flush during refill of 0x20");
    applyStimulus(32'h20, 32'h20);
    g = 0;
    while (!o_IBus_Read && g < 50) begin
      @(negedge i_Clk);
      g++;
    end
    checkOutput("t5_refill_seen", {31'd0, o_IBus_Read}, 32'd1);
    @(posedge i_Clk); #1;
    i_Flush = 1'b1;
    @(posedge i_Clk); #1;
    i_Flush = 1'b0;
    drain("t5a_drain");
    start = bus_log.size();
    applyStimulus(32'h24, 32'h24);
    drain("t5b_drain");
    checkBusLog("t5_bus", start, 32'h20);
`ifdef ICACHE_STATS_EN
    exp_hit = 32'd0; exp_miss = 32'd1;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    checkOutput("t5_hits", o_HitCount, exp_hit);
    checkOutput("t5_misses", o_MissCount, exp_miss);

    $display("[TB] reset during refill");
    i_RdEn = 1'b1;
    i_Addr = 32'h80;
    @(posedge i_Clk); #1;
    i_RdEn = 1'b0;
    g = 0;
    @(negedge i_Clk);
    while (!o_IBus_Read && g < 50) begin
      @(negedge i_Clk);
      g++;
    end
    checkOutput("t6_refill_seen", {31'd0, o_IBus_Read}, 32'd1);
    i_Rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("t6_rst_busread", {31'd0, o_IBus_Read}, 32'd0);
    checkOutput("t6_rst_stall", {31'd0, o_Stall}, 32'd0);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    @(posedge i_Clk); #1;
    checkOutput("t6_hits", o_HitCount, 32'd0);
    checkOutput("t6_misses", o_MissCount, 32'd0);
    start = bus_log.size();
    applyStimulus(32'h04, 32'h04);
    drain("t6_drain");
    checkBusLog("t6_bus", start, 32'h00);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
